// File: rtl/contador_pkg.sv
// Shared constants for the universal counter slice.
package contador_pkg;
  localparam int WIDTH_DEF   = 8;
  localparam int PRESC_W_DEF = 4;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
endpackage

// File: rtl/contador_univ_if.sv
// Control/status bundle of contador_univ; master drives controls, slave returns count and flags.
interface contador_univ_if #(
  parameter int WIDTH   = contador_pkg::WIDTH_DEF,
  parameter int PRESC_W = contador_pkg::PRESC_W_DEF
);
  logic               en;
  logic               up;
  logic               sat;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   mod_max;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   out;
  logic               tc;
  logic               evt;

  modport master (
    output en, up, sat, load, load_val, mod_max, presc,
    input  out, tc, evt
  );
  modport slave (
    input  en, up, sat, load, load_val, mod_max, presc,
    output out, tc, evt
  );
endinterface

// File: rtl/contador_presc.sv
// Rate divider: tick is high on one of every presc+1 enabled cycles.
module contador_presc
  import contador_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);
  // rem == presc means no enabled cycles elapsed since rst/clr/tick
  logic [PRESC_W-1:0] rem;

  assign tick = en && (rem == '0);

  always_ff @(posedge clk) begin
    if (rst || clr)  rem <= presc;
    else if (tick)   rem <= presc;
    else if (en)     rem <= rem - 1'b1;
  end
endmodule

// File: rtl/contador_univ.sv
// Universal up/down counter with range limit, load, wrap/saturate and limit event.
// Optional prescaler compiled in with CONTADOR_PRESCALER_EN.
module contador_univ
  import contador_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input logic            clk,
  input logic            rst,
  contador_univ_if.slave bus
);
  logic [WIDTH-1:0] cnt, nxt, ld_clamped;
  logic             evt_q, nxt_evt, tick, step;

`ifdef CONTADOR_PRESCALER_EN
  contador_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.load),
    .en    (bus.en),
    .presc (bus.presc),
    .tick  (tick)
  );
`else
  logic unused_presc;
  assign unused_presc = ^bus.presc;
  assign tick = 1'b1;
`endif

  assign step       = bus.en & tick;
  assign ld_clamped = (bus.load_val > bus.mod_max) ? bus.mod_max : bus.load_val;

  always_comb begin
    nxt     = cnt;
    nxt_evt = 1'b0;
    if (bus.up == DIR_UP) begin
      if (cnt >= bus.mod_max) begin
        nxt     = (bus.sat == MODE_SAT) ? bus.mod_max : '0;
        nxt_evt = 1'b1;
      end else begin
        nxt = cnt + 1'b1;
      end
    end else begin
      if (cnt == '0) begin
        nxt     = (bus.sat == MODE_SAT) ? '0 : bus.mod_max;
        nxt_evt = 1'b1;
      end else if (cnt > bus.mod_max) begin
        // out of range after a mod_max shrink: clamp quietly, not a limit event
        nxt = bus.mod_max;
      end else begin
        nxt = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      evt_q <= 1'b0;
    end else if (bus.load) begin
      cnt   <= ld_clamped;
      evt_q <= 1'b0;
    end else if (step) begin
      cnt   <= nxt;
      evt_q <= nxt_evt;
    end else begin
      evt_q <= 1'b0;
    end
  end

  assign bus.out = cnt;
  assign bus.evt = evt_q;
  assign bus.tc  = ((bus.up == DIR_UP) && (cnt >= bus.mod_max)) ||
                   ((bus.up == DIR_DOWN) && (cnt == '0));
endmodule

// File: doc/contador_univ.md
# contador_univ

Parametrised universal counter: the successor to the team's fixed 8-bit up-counter. Counts up or down over a run-time programmable range 0..mod_max, supports synchronous parallel load and a wrap/saturate mode, and flags terminal count and limit events. An optional compiled-in prescaler divides the count rate. It is used as the general timer and event counter in lab designs.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRESC_W, 4, prescaler divisor width in bits (used only with the prescaler compiled in)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  count enable, active-high
- up  in  1  direction: 1 = up, 0 = down
- sat  in  1  mode: 1 = saturate at limits, 0 = wrap
- load  in  1  synchronous parallel load strobe
- load_val  in  WIDTH  value to load
- mod_max  in  WIDTH  inclusive upper limit of the count range
- presc  in  PRESC_W  prescaler divisor minus one; always present, ignored when the prescaler is compiled out
- out  out  WIDTH  count value, registered
- tc  out  1  terminal count, combinational from out/up/mod_max
- evt  out  1  limit event pulse, registered

## Operation
- Priority per clock edge is rst > load > step > hold.
- rst: out = 0, evt = 0, prescaler count = 0.
- load: out = min(load_val, mod_max), evt = 0, prescaler count = 0. load takes effect regardless of en.
- Step: occurs when en = 1 and the prescaler tick is 1. Without the prescaler, the tick is always 1.
- Up step:
  - out < mod_max: out + 1.
  - out ≥ mod_max: 0 in wrap mode, mod_max in saturate mode. evt = 1.
- Down step:
  - 0 < out ≤ mod_max: out − 1.
  - out = 0: mod_max in wrap mode, 0 in saturate mode. evt = 1.
  - out > mod_max: out = mod_max (clamp), evt = 0.
- A reduced mod_max takes effect on the next step. out is never corrected without a step or load.
- mod_max = 0: every step leaves out = 0 and sets evt = 1.
- tc = (up & out ≥ mod_max) | (~up & out == 0).
- evt is 0 on every edge without a limit step, so it is a one-cycle pulse per limit step.
- Arithmetic is WIDTH bits, unsigned. No carry leaves the block.
- en = 0: out, evt = 0, and prescaler count all hold (evt clears).

## Timing
- out and evt update one cycle after the sampling edge. Load latency is 1 cycle.
- tc has zero latency relative to out, up and mod_max.
- Reset values: out = 0, evt = 0, tc = up ? (mod_max == 0) : 1.
- Prescaler: with en held high, a tick occurs every presc+1 cycles. The first tick comes presc+1 cycles after rst or load.
- sat, up and mod_max are sampled at every step edge. No registration is applied to them.

## Configuration
- CONTADOR_PRESCALER_EN defined: the prescaler is instantiated and steps occur once per presc+1 enabled cycles.
- CONTADOR_PRESCALER_EN undefined: no prescaler logic is built, every enabled cycle steps, and presc is unconnected internally.

## Structure
- Package contador_pkg holds:
  - Mode constants MODE_WRAP = 1'b0 and MODE_SAT = 1'b1.
  - Direction constants DIR_DOWN = 1'b0 and DIR_UP = 1'b1.
  - Default parameter constants for WIDTH and PRESC_W.
- Sub-module contador_presc, built only under CONTADOR_PRESCALER_EN:
  - Inputs clk, rst, clr (driven by load), en and presc.
  - Output tick.
  - Internal down-counter that reloads presc on each tick.

## Test plan
- Reset and wrap up: rst for 2 cycles, then up = 1, sat = 0, mod_max = 9, en = 1 for 12 cycles. Expect out 0..9, 0, 1. evt high exactly in the cycle out returns to 0. tc high while out = 9.
- Saturate down: load 3, up = 0, sat = 1, step 5 times. Expect out 2, 1, 0, 0, 0, with evt on each of the last two steps and tc = 1 from out = 0 on.
- Load clamp and priority:
  - load_val = 200, mod_max = 50: expect out = 50.
  - rst and load in the same cycle: expect out = 0.
  - load with en = 0: expect out = load_val.
- Range shrink: count up to 40 with mod_max = 63, then set mod_max = 20.
  - Up step: expect out 0 (wrap) or 20 (sat), with evt = 1.
  - Down step from 40: expect out = 20, evt = 0.
- Enable gating: toggle en every cycle while counting up from 0. Expect one increment per en-high cycle and out held while en = 0.
- Prescaler (macro defined): presc = 3, en = 1 for 16 cycles from reset. Expect out = 4, with increments exactly at cycles 4, 8, 12, 16. With the macro undefined, the same stimulus gives out = 16 mod (mod_max + 1).
